// File: rtl/multi_btn_debounce.sv
// N-channel push-button debouncer with a shared sample-tick prescaler.
// Each channel produces a clean level, press/release pulses and an optional auto-repeat train.
module multi_btn_debounce #(
    parameter int unsigned N_CH         = 5,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter int unsigned REPEAT_EN    = 0,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_status,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            tick
);
    localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW     = $clog2(STABLE_TICKS + 1);
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW     = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam bit          REP_ON = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RATE  = 2'd2
    } rep_state_e;

    logic [PW-1:0]   div_q;
    logic [PW-1:0]   div_d;
    logic [N_CH-1:0] meta_q;
    logic [N_CH-1:0] sync_q;

    // Shared prescaler; tick is registered so it is high while div_q == TICK_DIV-1
    always_comb begin
        div_d = div_q + PW'(1);
        if (div_q == PW'(TICK_DIV - 1)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick   <= 1'b0;
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            div_q  <= div_d;
            tick   <= (div_d == PW'(TICK_DIV - 1));
            meta_q <= btn_in;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          status_q;
        logic          status_d;
        logic          press_q;
        logic          release_q;
        logic          rise_c;
        logic          fall_c;
        rep_state_e    st_q;
        rep_state_e    st_d;
        logic [RW-1:0] rcnt_q;
        logic [RW-1:0] rcnt_d;
        logic          rep_q;
        logic          rep_d;

        // Stability qualification: any tick that agrees with the current level restarts the count
        always_comb begin
            cnt_d    = cnt_q;
            status_d = status_q;
            if (tick) begin
                if (sync_q[i] == status_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                    cnt_d    = '0;
                    status_d = ~status_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        assign rise_c = status_d & ~status_q;
        assign fall_c = ~status_d & status_q;

        // Auto-repeat next-state; a falling level always wins so no pulse accompanies release
        always_comb begin
            st_d   = st_q;
            rcnt_d = rcnt_q;
            rep_d  = 1'b0;
            if (fall_c) begin
                st_d   = R_IDLE;
                rcnt_d = '0;
            end else begin
                case (st_q)
                    R_IDLE: begin
                        if (rise_c) begin
                            st_d   = R_DELAY;
                            rcnt_d = '0;
                        end
                    end
                    R_DELAY: begin
                        if (tick) begin
                            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                                rep_d  = REP_ON;
                                rcnt_d = '0;
                                st_d   = R_RATE;
                            end else if (rcnt_q != {RW{1'b1}}) begin
                                rcnt_d = rcnt_q + RW'(1);
                            end
                        end
                    end
                    R_RATE: begin
                        if (tick) begin
                            if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
                                rep_d  = REP_ON;
                                rcnt_d = '0;
                            end else if (rcnt_q != {RW{1'b1}}) begin
                                rcnt_d = rcnt_q + RW'(1);
                            end
                        end
                    end
                    default: begin
                        st_d   = R_IDLE;
                        rcnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                status_q  <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                st_q      <= R_IDLE;
                rcnt_q    <= '0;
                rep_q     <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                status_q  <= status_d;
                press_q   <= rise_c;
                release_q <= fall_c;
                st_q      <= st_d;
                rcnt_q    <= rcnt_d;
                rep_q     <= rep_d;
            end
        end

        assign btn_status[i]  = status_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = rep_q;
    end

endmodule
